// File: rtl/mod_reduce_pkg.sv
// mod_reduce_pkg: shared widths, default modulus and Barrett constant for the 300-to-256-bit reducer
package mod_reduce_pkg;
    localparam int IN_W  = 300;
    localparam int OUT_W = 256;
    localparam int R_W   = 258;
    localparam int Q_W   = 45;
    localparam int MU_W  = 257;
    localparam int Q2_W  = Q_W + MU_W;
    localparam logic [OUT_W-1:0] DEFAULT_MODULUS =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    // M = 2^256 - c with c^2 < M, so floor(2^512 / M) = 2^256 + c exactly
    localparam logic [MU_W-1:0] DEFAULT_MU = {1'b1, 256'h1_000003D1};
    typedef logic [OUT_W-1:0] elem_t;
endpackage

// File: rtl/mod_reduce_300to256_correct.sv
// mod_correct: folds a Barrett remainder r in [0, 3M) into [0, M) using parallel compare/select
module mod_correct
    import mod_reduce_pkg::*;
#(
    parameter elem_t M = DEFAULT_MODULUS
) (
    input  logic [R_W-1:0] r_i,
    output elem_t          res_o
);
    localparam logic [R_W-1:0] M1 = {2'b00, M};
    localparam logic [R_W-1:0] M2 = {1'b0, M, 1'b0};
    assign res_o = elem_t'((r_i >= M2) ? r_i - M2 : (r_i >= M1) ? r_i - M1 : r_i);
endmodule

// File: rtl/mod_reduce_300to256.sv
// mod_reduce_300to256: pipelined Barrett reduction of a 300-bit operand modulo a 256-bit M.
// TOP_LEVEL_IN_REG_EN adds an input register stage (latency 3 instead of 2).
module mod_reduce_300to256
    import mod_reduce_pkg::*;
#(
    parameter elem_t           MODULUS = DEFAULT_MODULUS,
    parameter logic [MU_W-1:0] MU      = DEFAULT_MU
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] o
);
    logic [IN_W-1:0] x_s;
    logic [Q_W-1:0]  q3;
    logic [R_W-1:0]  r_d, r_q;
    elem_t           o_d, o_q;

`ifdef TOP_LEVEL_IN_REG_EN
    logic [IN_W-1:0] x_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) x_q <= '0;
        else       x_q <= x;
    assign x_s = x_q;
`else
    assign x_s = x;
`endif

    // r only needs the low 258 bits: the true remainder is below 3M < 2^258
    assign q3  = Q_W'((Q2_W'(x_s[IN_W-1:OUT_W-1]) * Q2_W'(MU)) >> MU_W);
    assign r_d = x_s[R_W-1:0] - R_W'(R_W'(q3) * R_W'(MODULUS));

    mod_correct #(.M(MODULUS)) u_corr (.r_i(r_q), .res_o(o_d));

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_q <= '0;
            o_q <= '0;
        end else begin
            r_q <= r_d;
            o_q <= o_d;
        end

    assign o = o_q;
endmodule

// File: tb/tb_mod_reduce_300to256.sv
// tb_mod_reduce_300to256: scoreboard bench comparing o against a bignum x mod M model.
// Honours TOP_LEVEL_IN_REG_EN for the expected latency.
module tb_mod_reduce_300to256;
    import mod_reduce_pkg::*;
`ifdef TOP_LEVEL_IN_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam elem_t M = DEFAULT_MODULUS;

    typedef struct {
        elem_t e;
        int    due;
        string tag;
    } sb_t;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [IN_W-1:0] x     = '0;
    elem_t           o;
    sb_t             sb[$];
    int              cyc   = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    bit              zero_win = 1'b1;
    logic [IN_W-1:0] mx = IN_W'(M);
    longint          ks[6] = '{1, 2, 3, (64'd1 << 44) - 1, (64'd1 << 43) + 5, 64'h123456789AB};

    mod_reduce_300to256 top_level (.clk(clk), .reset(reset), .x(x), .o(o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input elem_t got, input elem_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic elem_t gold(input logic [IN_W-1:0] v);
        logic [IN_W-1:0] m;
        m = IN_W'(M);
        return elem_t'(v % m);
    endfunction

    function automatic logic [IN_W-1:0] rnd();
        logic [IN_W-1:0] t;
        t = '0;
        for (int i = 0; i < 10; i++) t = {t[IN_W-33:0], $urandom};
        return t;
    endfunction

    task automatic drive_exp(input string tag, input logic [IN_W-1:0] v, input elem_t ev);
        @(negedge clk);
        x = v;
        sb.push_back('{e: ev, due: cyc + LAT, tag: tag});
    endtask

    task automatic drive(input string tag, input logic [IN_W-1:0] v);
        drive_exp(tag, v, gold(v));
    endtask

    // after reset, o must read 0 until the first post-reset operand is due
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check(sb[0].tag, o, sb[0].e);
                void'(sb.pop_front());
                zero_win = 1'b0;
            end else if (zero_win) check("idle_zero", o, '0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check("rst_o", o, '0);
        @(negedge clk) reset = 1'b0;
        repeat (4) drive("zero", '0);
        drive_exp("m_minus_1", mx - 1, M - 1);
        drive_exp("m", mx, '0);
        drive_exp("2m_plus_7", 2 * mx + 7, elem_t'(7));
        drive("all_ones", '1);
        drive_exp("pow256", IN_W'(1) << 256, 256'h1_000003D1);
        foreach (ks[i]) begin
            drive("k_m", IN_W'(ks[i]) * mx);
            drive("k_m_minus_1", IN_W'(ks[i]) * mx - 1);
            drive("k_m_plus_m_minus_1", IN_W'(ks[i]) * mx + mx - 1);
        end
        for (int i = 0; i < 40; i++) drive("random", rnd());
        for (int i = 0; i < 5; i++) drive("pre_rst", rnd());
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        zero_win = 1'b1;
        #1 check("async_rst", o, '0);
        x = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) drive("post_rst", rnd());
        repeat (LAT + 2) @(posedge clk);
        #2 check("drain", elem_t'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
